aes_job_scheduler: RTL and testbench

AES_JOB_SCHEDULER -- requirements
Module: aes_job_scheduler

---
 rtl/aes_ctrl_pkg.sv | 7 +
 rtl/rr_arbiter2.sv | 14 +
 rtl/aes_job_scheduler.sv | 127 ++++++++++++
 tb/tb_aes_job_scheduler.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared scheduler state type and parameter defaults
// Contents: sched_t FSM encoding, DATA_W_DEF (bus width), TIMEOUT_DEF (WAIT cycle budget)
package aes_ctrl_pkg;
    localparam int DATA_W_DEF  = 128;
    localparam int TIMEOUT_DEF = 63;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter returning the winning requester index
// Ports: request[1:0] pending requests, last_grant index served last,
//        grant winning index, any high when at least one request is pending
module rr_arbiter2 (
    input  logic [1:0] request,
    input  logic       last_grant,
    output logic       grant,
    output logic       any
);
    always_comb begin
        any   = |request;
        grant = &request ? ~last_grant : request[1];
    end
endmodule

// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler: serialises jobs from two requesters onto one AES core
// Ports: clk/reset (sync, active-high); req_* job intake per requester with
//        req_ready accept strobe; core_* start/select/data/key to the core and
//        core_done/core_dout back; rsp_* shared response with per-requester
//        valid and error flag; busy high whenever a job is in flight
module aes_job_scheduler
    import aes_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_data,
    input  logic [2*DATA_W-1:0] req_key,
    input  logic [1:0]          req_encrypt,
    output logic                core_start,
    output logic                core_keyChange,
    output logic                core_selCypher,
    output logic [DATA_W-1:0]   core_din,
    output logic [DATA_W-1:0]   core_key,
    input  logic                core_done,
    input  logic [DATA_W-1:0]   core_dout,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err,
    output logic                busy
);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    sched_t            state_q, state_d;
    logic              g_q, last_q, enc_q, key_valid_q, err_q;
    logic [DATA_W-1:0] din_q, key_q, cached_q, rsp_data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              arb_g, arb_any, timeout;

    rr_arbiter2 u_arb (
        .request    (req_valid),
        .last_grant (last_q),
        .grant      (arb_g),
        .any        (arb_any)
    );

    assign timeout = cnt_q == CNT_W'(TIMEOUT);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // core_done takes priority over timeout in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = arb_any ? ISSUE : IDLE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = (core_done || timeout) ? RESP : WAIT;
            RESP:    state_d = rsp_ready[g_q] ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = {arb_g, ~arb_g} & {2{state_q == IDLE && arb_any}};
        core_start     = state_q == ISSUE;
        core_keyChange = core_start && (!key_valid_q || key_q != cached_q);
        core_selCypher = core_start && enc_q;
        core_din       = din_q;
        core_key       = key_q;
        rsp_valid      = {g_q, ~g_q} & {2{state_q == RESP}};
        rsp_data       = rsp_data_q;
        rsp_err        = err_q;
        busy           = state_q != IDLE;
    end

    // Job registers are cleared on response hand-off so an idle scheduler
    // presents the same outputs as a freshly reset one.
    always_ff @(posedge clk) begin
        if (reset) begin
            g_q         <= 1'b0;
            last_q      <= 1'b1;
            enc_q       <= 1'b0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
            din_q       <= '0;
            key_q       <= '0;
            cached_q    <= '0;
            rsp_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (arb_any) begin
                    g_q   <= arb_g;
                    enc_q <= req_encrypt[arb_g];
                    din_q <= arb_g ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
                    key_q <= arb_g ? req_key[2*DATA_W-1:DATA_W] : req_key[DATA_W-1:0];
                end
                ISSUE: begin
                    cached_q    <= key_q;
                    key_valid_q <= 1'b1;
                    cnt_q       <= '0;
                end
                WAIT: if (core_done) begin
                    rsp_data_q <= core_dout;
                    err_q      <= 1'b0;
                end else if (timeout) begin
                    rsp_data_q  <= '0;
                    err_q       <= 1'b1;
                    key_valid_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                RESP: if (rsp_ready[g_q]) begin
                    last_q     <= g_q;
                    rsp_data_q <= '0;
                    err_q      <= 1'b0;
                    enc_q      <= 1'b0;
                    din_q      <= '0;
                    key_q      <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_job_scheduler.sv
// tb_aes_job_scheduler: directed self-checking bench for aes_job_scheduler
module tb_aes_job_scheduler;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   req_valid = '0, req_ready, req_encrypt = '0, rsp_valid, rsp_ready = '0;
    logic [255:0] req_data = '0, req_key = '0;
    logic         core_start, core_keyChange, core_selCypher, core_done = 1'b0, rsp_err, busy;
    logic [127:0] core_din, core_key, core_dout = '0, rsp_data;
    int           checks = 0, errors = 0;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] D0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] D1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] R0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] R1 = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_job_scheduler dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_key(req_key), .req_encrypt(req_encrypt),
        .core_start(core_start), .core_keyChange(core_keyChange), .core_selCypher(core_selCypher),
        .core_din(core_din), .core_key(core_key), .core_done(core_done), .core_dout(core_dout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " req_ready"}, req_ready, 0);
        chk({tag, " rsp_valid"}, rsp_valid, 0);
        chk({tag, " core_start"}, core_start, 0);
        chk({tag, " core_keyChange"}, core_keyChange, 0);
        chk({tag, " core_selCypher"}, core_selCypher, 0);
        chk({tag, " core_din"}, core_din, 0);
        chk({tag, " core_key"}, core_key, 0);
        chk({tag, " rsp_data"}, rsp_data, 0);
        chk({tag, " rsp_err"}, rsp_err, 0);
        chk({tag, " busy"}, busy, 0);
    endtask

    // One complete job: grant, ISSUE, core_done n cycles after ISSUE,
    // optional stall cycles in RESP, then the response hand-off.
    task automatic job(input string tag, input logic [1:0] v, input logic hold, input logic g,
                       input logic [127:0] d0, input logic [127:0] d1,
                       input logic [127:0] k0, input logic [127:0] k1, input logic [1:0] enc,
                       input int n, input int stall, input logic [127:0] r, input logic kc);
        req_valid = v;
        req_data = {d1, d0};
        req_key = {k1, k0};
        req_encrypt = enc;
        #1 chk({tag, " grant"}, req_ready, {g, ~g});
        tick;
        if (!hold) req_valid = 2'b00;
        chk({tag, " start"}, core_start, 1);
        chk({tag, " keyChange"}, core_keyChange, kc);
        chk({tag, " selCypher"}, core_selCypher, enc[g]);
        chk({tag, " din"}, core_din, g ? d1 : d0);
        chk({tag, " key"}, core_key, g ? k1 : k0);
        for (int i = 1; i < n; i++) begin
            tick;
            chk({tag, " wait rsp_valid"}, rsp_valid, 0);
            chk({tag, " wait req_ready"}, req_ready, 0);
        end
        tick;
        core_done = 1'b1;
        core_dout = r;
        #1 chk({tag, " latency"}, rsp_valid, 0);
        tick;
        core_done = 1'b0;
        chk({tag, " rsp_valid"}, rsp_valid, {g, ~g});
        chk({tag, " rsp_data"}, rsp_data, r);
        chk({tag, " rsp_err"}, rsp_err, 0);
        for (int s = 0; s < stall; s++) begin
            rsp_ready = (s == 2) ? {~g, g} : 2'b00;
            core_done = (s == 3);
            core_dout = ~r;
            tick;
            chk({tag, " stall rsp_valid"}, rsp_valid, {g, ~g});
            chk({tag, " stall rsp_data"}, rsp_data, r);
        end
        core_done = 1'b0;
        rsp_ready = {g, ~g};
        tick;
        rsp_ready = 2'b00;
        chk({tag, " done rsp_valid"}, rsp_valid, 0);
        chk({tag, " done busy"}, busy, 0);
        chk({tag, " done rsp_data"}, rsp_data, 0);
    endtask

    initial begin
        tick;
        tick;
        chk_zero("reset");
        reset = 1'b0;
        tick;
        chk_zero("idle");
        core_done = 1'b1;
        core_dout = R1;
        tick;
        core_done = 1'b0;
        chk_zero("idle core_done");
        req_valid = 2'b01;
        #1 req_valid = 2'b00;
        tick;
        chk_zero("dropped request");
        job("j1", 2'b01, 1'b0, 1'b0, D0, D1, K1, K2, 2'b01, 12, 0, R0, 1'b1);
        job("j2 same key", 2'b01, 1'b0, 1'b0, D1, D0, K1, K2, 2'b00, 3, 0, R1, 1'b0);
        job("j3 new key", 2'b10, 1'b0, 1'b1, D0, D1, K1, K2, 2'b10, 1, 0, R0, 1'b1);
        job("rr0", 2'b11, 1'b1, 1'b0, D0, D1, K2, K2, 2'b10, 2, 0, R0, 1'b0);
        job("rr1", 2'b11, 1'b1, 1'b1, D0, D1, K2, K2, 2'b10, 2, 0, R1, 1'b0);
        job("rr2", 2'b11, 1'b1, 1'b0, D0, D1, K2, K2, 2'b10, 2, 0, R1, 1'b0);
        job("rr3", 2'b11, 1'b1, 1'b1, D0, D1, K2, K2, 2'b10, 2, 0, R0, 1'b0);
        req_valid = 2'b01;
        req_data = {D1, D0};
        req_key = {K2, K2};
        req_encrypt = 2'b01;
        #1 chk("to grant", req_ready, 2'b01);
        tick;
        req_valid = 2'b00;
        chk("to keyChange", core_keyChange, 0);
        for (int i = 1; i <= 64; i++) begin
            tick;
            chk("to waiting", rsp_valid, 0);
        end
        tick;
        chk("to rsp_valid", rsp_valid, 2'b01);
        chk("to rsp_err", rsp_err, 1);
        chk("to rsp_data", rsp_data, 0);
        rsp_ready = 2'b01;
        tick;
        rsp_ready = 2'b00;
        chk("to busy", busy, 0);
        chk("to err cleared", rsp_err, 0);
        job("after timeout", 2'b01, 1'b0, 1'b0, D0, D1, K2, K1, 2'b00, 2, 0, R1, 1'b1);
        job("stall", 2'b01, 1'b0, 1'b0, D1, D0, K2, K1, 2'b01, 4, 5, R0, 1'b0);
        req_valid = 2'b10;
        req_data = {D1, D0};
        req_key = {K1, K1};
        req_encrypt = 2'b00;
        tick;
        req_valid = 2'b00;
        chk("rst issue", core_start, 1);
        tick;
        tick;
        chk("rst in wait", busy, 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk_zero("rst mid job");
        core_done = 1'b1;
        core_dout = R1;
        tick;
        core_done = 1'b0;
        chk_zero("rst late done");
        job("rst next", 2'b11, 1'b0, 1'b0, D0, D1, K1, K1, 2'b01, 2, 0, R1, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
